line_buffer: RTL and testbench



---
 rtl/line_buffer_if.sv | 54 +++++
 rtl/line_buffer.sv | 111 +++++++++++
 tb/tb_line_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_if.sv
// Bundle of the fill, CPU read/write, drain and status signals of one cache line buffer.
// The master side is the CPU/memory controller; the slave side is the line buffer itself.
interface line_buffer_if #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 16,
   parameter int BEAT_WIDTH = 64
);
   localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int OFS_W = $clog2(WORDS);
   localparam int BE_W  = WORD_WIDTH / 8;

   logic                  fill_valid;
   logic [BEAT_WIDTH-1:0] fill_data;
   logic                  fill_ready;

   logic                  rd_en;
   logic [OFS_W-1:0]      rd_offset;
   logic [WORD_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   logic                  wr_en;
   logic [OFS_W-1:0]      wr_offset;
   logic [WORD_WIDTH-1:0] wr_data;
   logic [BE_W-1:0]       wr_be;

   logic                  drain_req;
   logic                  inval;
   logic                  drain_valid;
   logic [BEAT_WIDTH-1:0] drain_data;
   logic                  drain_last;
   logic                  drain_ready;

   logic                  line_valid;
   logic                  dirty;
   logic                  busy;

   modport master (
      output fill_valid, fill_data, input fill_ready,
      output rd_en, rd_offset, input rd_data, rd_valid,
      output wr_en, wr_offset, wr_data, wr_be,
      output drain_req, inval, drain_ready,
      input  drain_valid, drain_data, drain_last,
      input  line_valid, dirty, busy
   );

   modport slave (
      input  fill_valid, fill_data, output fill_ready,
      input  rd_en, rd_offset, output rd_data, rd_valid,
      input  wr_en, wr_offset, wr_data, wr_be,
      input  drain_req, inval, drain_ready,
      output drain_valid, drain_data, drain_last,
      output line_valid, dirty, busy
   );
endinterface

// File: rtl/line_buffer.sv
// Single cache line buffer: filled by memory beats, read/written by CPU words with byte
// enables, and written back (drained) beat by beat or discarded.
module line_buffer #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 16,
   parameter int BEAT_WIDTH = 64
) (
   input logic          clk,
   input logic          rst_n,
   line_buffer_if.slave lb
);
   localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int OFS_W = $clog2(WORDS);
   localparam int BE_W  = WORD_WIDTH / 8;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {EMPTY, FILL, VALID, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [LINE_WIDTH-1:0] line_q;
   logic                  fill_acc, drain_acc, in_valid, wr_act, bypass;
   logic [WORD_WIDTH-1:0] rd_word, wr_old, wr_word;
   logic [OFS_W-1:0]      wr_ofs;

   function automatic logic [WORD_WIDTH-1:0] merge_word(
      input logic [WORD_WIDTH-1:0] old_w,
      input logic [WORD_WIDTH-1:0] new_w,
      input logic [BE_W-1:0]       be
   );
      logic [WORD_WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

   assign wr_ofs    = lb.wr_offset;
   assign fill_acc  = lb.fill_valid & lb.fill_ready;
   assign drain_acc = lb.drain_valid & lb.drain_ready;
   assign in_valid  = (state == VALID);
   // inval wins over a same-cycle write; a write with no byte enables is a no-op
   assign wr_act    = in_valid & lb.wr_en & ~lb.inval & (|lb.wr_be);
   assign bypass    = wr_act & (lb.rd_offset == wr_ofs);
   assign rd_word   = line_q[int'(lb.rd_offset)*WORD_WIDTH +: WORD_WIDTH];
   assign wr_old    = line_q[int'(wr_ofs)*WORD_WIDTH +: WORD_WIDTH];
   assign wr_word   = merge_word(wr_old, lb.wr_data, lb.wr_be);

   // drain_data only changes when the counter advances, so it is stable under back-pressure
   assign lb.drain_data = line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (fill_acc || drain_acc) cnt_nxt = (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
      case (state)
         EMPTY, FILL: if (fill_acc) state_nxt = (cnt == LAST_BEAT) ? VALID : FILL;
         VALID: begin
            if (lb.inval)          state_nxt = EMPTY;
            else if (lb.drain_req) state_nxt = DRAIN;
         end
         DRAIN: if (drain_acc && cnt == LAST_BEAT) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // stage p1: control state and registered status/handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= EMPTY;
         cnt            <= '0;
         lb.fill_ready  <= 1'b1;
         lb.line_valid  <= 1'b0;
         lb.busy        <= 1'b0;
         lb.drain_valid <= 1'b0;
         lb.drain_last  <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         lb.fill_ready  <= (state_nxt == EMPTY) || (state_nxt == FILL);
         lb.line_valid  <= (state_nxt == VALID);
         lb.busy        <= (state_nxt == FILL) || (state_nxt == DRAIN);
         lb.drain_valid <= (state_nxt == DRAIN);
         lb.drain_last  <= (state_nxt == DRAIN) && (cnt_nxt == LAST_BEAT);
      end
   end

   // stage p1: line storage, read port and dirty flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q      <= '0;
         lb.rd_data  <= '0;
         lb.rd_valid <= 1'b0;
         lb.dirty    <= 1'b0;
      end else begin
         lb.rd_valid <= in_valid & lb.rd_en;
         if (in_valid && lb.rd_en) lb.rd_data <= bypass ? wr_word : rd_word;
         if (fill_acc) line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= lb.fill_data;
         if (wr_act) begin
            line_q[int'(wr_ofs)*WORD_WIDTH +: WORD_WIDTH] <= wr_word;
            lb.dirty <= 1'b1;
         end
         if ((state != VALID && state_nxt == VALID) || (in_valid && lb.inval) ||
             (drain_acc && cnt == LAST_BEAT))
            lb.dirty <= 1'b0;
      end
   end
endmodule

// File: tb/tb_line_buffer.sv
// Directed-plus-random bench for line_buffer against a byte-array model of the cache line.
`timescale 1ns/1ps
module tb_line_buffer;
   localparam int LW = 128;
   localparam int WW = 16;
   localparam int BW = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   line_buffer_if #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .BEAT_WIDTH(BW)) bus();

   line_buffer #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .BEAT_WIDTH(BW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .lb   (bus)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;

   // model: 16 bytes of line, byte 0 is the least significant byte of beat 0
   logic [7:0]  mb [16];
   bit          m_valid, m_dirty, m_drain;
   int          m_fill;
   logic [15:0] m_rd;

   function automatic logic [15:0] mword(input int off);
      return {mb[2*off+1], mb[2*off]};
   endfunction

   function automatic logic [63:0] mbeat(input int k);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = mb[k*8+i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mb[i] = 8'h00;
      m_valid = 0; m_dirty = 0; m_drain = 0; m_fill = 0; m_rd = 16'h0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_beat(input logic [63:0] d);
      bus.fill_valid = 1'b1;
      bus.fill_data  = d;
      if (!m_valid && !m_drain) begin
         for (int i = 0; i < 8; i++) mb[m_fill*8+i] = d[i*8 +: 8];
         m_fill++;
         if (m_fill == 2) begin m_fill = 0; m_valid = 1; m_dirty = 0; end
      end
      step();
      bus.fill_valid = 1'b0;
   endtask

   // one cycle of CPU activity; write applied to the model before the read (bypass)
   task automatic access(input bit rd, input int roff, input bit wr, input int woff,
                         input logic [15:0] wd, input logic [1:0] be, input string tag);
      bus.rd_en = rd; bus.rd_offset = 3'(roff);
      bus.wr_en = wr; bus.wr_offset = 3'(woff); bus.wr_data = wd; bus.wr_be = be;
      if (m_valid && wr && be != 2'b00) begin
         if (be[0]) mb[2*woff]   = wd[7:0];
         if (be[1]) mb[2*woff+1] = wd[15:8];
         m_dirty = 1;
      end
      if (m_valid && rd) m_rd = mword(roff);
      step();
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_be = 2'b00;
      check({tag, "_rvld"}, bus.rd_valid, m_valid && rd);
      check({tag, "_rdat"}, bus.rd_data, m_rd);
   endtask

   task automatic status(input string tag);
      check({tag, "_lval"}, bus.line_valid, m_valid);
      check({tag, "_dirty"}, bus.dirty, m_dirty);
      check({tag, "_busy"}, bus.busy, m_drain || (!m_valid && m_fill != 0));
      check({tag, "_frdy"}, bus.fill_ready, !m_valid && !m_drain);
   endtask

   initial begin
      int idx, budget;
      logic [63:0] b0, b1;
      model_reset();
      bus.fill_valid = 0; bus.fill_data = '0; bus.rd_en = 0; bus.rd_offset = '0;
      bus.wr_en = 0; bus.wr_offset = '0; bus.wr_data = '0; bus.wr_be = '0;
      bus.drain_req = 0; bus.inval = 0; bus.drain_ready = 0;

      // reset values
      step(); step();
      check("rst_dval", bus.drain_valid, 1'b0);
      check("rst_dlast", bus.drain_last, 1'b0);
      check("rst_rvld", bus.rd_valid, 1'b0);
      check("rst_rdat", bus.rd_data, 16'h0);
      status("rst");
      rst_n = 1'b1;
      check("post_rst_frdy", bus.fill_ready, 1'b1);

      // CPU access ignored while EMPTY
      access(1, 3, 1, 3, 16'hFFFF, 2'b11, "empty_acc");
      status("empty");

      // directed fill and read
      fill_beat(64'h0003_0002_0001_0000);
      status("fill1");
      fill_beat(64'h0007_0006_0005_0004);
      status("fill2");
      access(1, 5, 0, 0, 16'h0, 2'b00, "rd5");
      check("rd5_const", bus.rd_data, 16'h0005);
      access(0, 0, 0, 0, 16'h0, 2'b00, "idle_hold");

      // byte-enabled write and same-cycle bypass
      access(0, 0, 1, 2, 16'hABCD, 2'b10, "wr2");
      status("wr2");
      access(1, 2, 0, 0, 16'h0, 2'b00, "rd2");
      check("rd2_const", bus.rd_data, 16'hAB02);
      access(1, 7, 1, 7, 16'h1234, 2'b11, "byp7");
      check("byp7_const", bus.rd_data, 16'h1234);

      // random reads/writes, including different-offset same-cycle pairs
      for (int i = 0; i < 24; i++)
         access($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), 16'($urandom), 2'($urandom), "rnd");
      status("rnd");

      // drain with same-cycle write, held off by back-pressure
      bus.drain_req = 1'b1;
      access(0, 0, 1, 1, 16'h5A5A, 2'b01, "drw");
      bus.drain_req = 1'b0;
      m_valid = 0; m_drain = 1;
      for (int i = 0; i < 3; i++) begin
         check("dh_valid", bus.drain_valid, 1'b1);
         check("dh_data", bus.drain_data, mbeat(0));
         check("dh_last", bus.drain_last, 1'b0);
         status("dh");
         bus.fill_valid = 1'b1; bus.fill_data = 64'hDEAD;
         step();
         bus.fill_valid = 1'b0;
      end
      bus.drain_ready = 1'b1;
      step();
      check("d1_data", bus.drain_data, mbeat(1));
      check("d1_last", bus.drain_last, 1'b1);
      check("d1_valid", bus.drain_valid, 1'b1);
      step();
      bus.drain_ready = 1'b0;
      m_drain = 0; m_dirty = 0;
      check("d2_valid", bus.drain_valid, 1'b0);
      status("d2");

      // reset in the middle of a fill
      fill_beat(64'($urandom) << 32 | 64'($urandom));
      status("pre_rst");
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_dirty", bus.dirty, 1'b0);
      step();
      rst_n = 1'b1;
      b0 = {32'($urandom), 32'($urandom)};
      b1 = {32'($urandom), 32'($urandom)};
      fill_beat(b0);
      fill_beat(b1);
      status("refill");
      check("refill_b0", mbeat(0), b0);
      for (int i = 0; i < 8; i++) access(1, i, 0, 0, 16'h0, 2'b00, "refill_rd");

      // write with no byte enables leaves a clean line clean
      access(1, 4, 1, 4, 16'hFFFF, 2'b00, "be0");
      status("be0");

      // inval beats drain_req and discards the same-cycle write
      access(0, 0, 1, 6, 16'h7777, 2'b11, "pre_inv");
      bus.inval = 1'b1; bus.drain_req = 1'b1;
      bus.wr_en = 1'b1; bus.wr_offset = 3'd0; bus.wr_data = 16'hEEEE; bus.wr_be = 2'b11;
      step();
      bus.inval = 1'b0; bus.drain_req = 1'b0; bus.wr_en = 1'b0; bus.wr_be = 2'b00;
      m_valid = 0; m_dirty = 0;
      check("inv_dval", bus.drain_valid, 1'b0);
      status("inv");
      step();
      check("inv_dval2", bus.drain_valid, 1'b0);

      // random fill, writes and randomly back-pressured drain
      fill_beat({32'($urandom), 32'($urandom)});
      fill_beat({32'($urandom), 32'($urandom)});
      for (int i = 0; i < 6; i++)
         access(0, 0, 1, $urandom_range(0, 7), 16'($urandom), 2'($urandom), "rwr");
      bus.drain_req = 1'b1;
      step();
      bus.drain_req = 1'b0;
      m_valid = 0; m_drain = 1;
      idx = 0; budget = 0;
      while (idx < 2 && budget < 64) begin
         bus.drain_ready = 1'($urandom_range(0, 1));
         if (bus.drain_ready) begin
            check("rd_dval", bus.drain_valid, 1'b1);
            check("rd_ddata", bus.drain_data, mbeat(idx));
            check("rd_dlast", bus.drain_last, idx == 1);
            idx++;
         end
         step();
         budget++;
      end
      bus.drain_ready = 1'b0;
      m_drain = 0; m_dirty = 0;
      check("rd_beats", idx, 2);
      check("rd_end_dval", bus.drain_valid, 1'b0);
      status("rd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
